// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for a 5-stage MIPS pipeline.
// A one-word buffer keeps a fetched instruction across a stall; DISCARD drains a stale request after a redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        if_id_write_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] buffer, buffer_next;
  logic [31:0] redirect, redirect_next;
  logic [31:0] pc_plus4;
  logic [31:0] new_instr;
  logic        load_instr;
  logic        load_bubble;
  logic        advance;

  assign advance     = pc_write_i & if_id_write_i;
  assign pc_plus4    = pc + 32'd4;
  assign imem_addr_o = pc;
  // The request is held low during reset so an abandoned fetch is never re-issued early.
  assign imem_req_o  = rst_i & (state != HOLD);

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    buffer_next   = buffer;
    redirect_next = redirect;
    new_instr     = 32'h0;
    load_instr    = 1'b0;
    load_bubble   = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack_i && flush_i) begin
          pc_next     = branch_target_i;
          load_bubble = 1'b1;
        end else if (imem_ack_i && advance) begin
          new_instr  = imem_data_i;
          load_instr = 1'b1;
          pc_next    = pc_plus4;
        end else if (imem_ack_i) begin
          buffer_next = imem_data_i;
          state_next  = HOLD;
          load_bubble = if_id_write_i;
        end else if (flush_i) begin
          redirect_next = branch_target_i;
          load_bubble   = 1'b1;
          state_next    = DISCARD;
        end else begin
          load_bubble = if_id_write_i;
        end
      end
      HOLD: begin
        if (flush_i) begin
          pc_next     = branch_target_i;
          load_bubble = 1'b1;
          state_next  = FETCH;
        end else if (advance) begin
          new_instr  = buffer;
          load_instr = 1'b1;
          pc_next    = pc_plus4;
          state_next = FETCH;
        end
      end
      DISCARD: begin
        // A flush arriving alongside the ack is the newest redirect and takes effect directly.
        if (flush_i) redirect_next = branch_target_i;
        if (imem_ack_i) begin
          pc_next    = flush_i ? branch_target_i : redirect;
          state_next = FETCH;
        end
        load_bubble = if_id_write_i | flush_i;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      buffer   <= 32'h0;
      redirect <= 32'h0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      buffer   <= buffer_next;
      redirect <= redirect_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_o       <= 32'h0;
      pc_plus4_o <= 32'h0;
      instr_o    <= 32'h0;
      valid_o    <= 1'b0;
    end else if (load_instr) begin
      pc_o       <= pc;
      pc_plus4_o <= pc_plus4;
      instr_o    <= new_instr;
      valid_o    <= 1'b1;
    end else if (load_bubble) begin
      pc_o       <= 32'h0;
      pc_plus4_o <= 32'h0;
      instr_o    <= 32'h0;
      valid_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a wait-state memory model, an IF/ID scoreboard queue,
// and a second instance reset at 32'hFFFF_FFFC to exercise PC wrap-around.
module tb_if_stage;

  localparam logic [31:0] PATTERN = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_write_i;
  logic        if_id_write_i;
  logic        flush_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o, pc_plus4_o, instr_o;
  logic        valid_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc, w_pc_plus4, w_instr;
  logic        w_valid;

  logic [1:0]  wait_states;
  logic [1:0]  mem_cnt;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  ifid_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk_i = ~clk_i;

  if_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_write_i(pc_write_i), .if_id_write_i(if_id_write_i),
    .flush_i(flush_i), .branch_target_i(branch_target_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .instr_o(instr_o), .valid_o(valid_o)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .pc_write_i(1'b1), .if_id_write_i(1'b1),
    .flush_i(1'b0), .branch_target_i(32'h0), .imem_req_o(w_req),
    .imem_addr_o(w_addr), .imem_ack_i(w_req), .imem_data_i(w_addr ^ PATTERN),
    .pc_o(w_pc), .pc_plus4_o(w_pc_plus4), .instr_o(w_instr), .valid_o(w_valid)
  );

  // Memory answers after wait_states cycles of continuous request; data is addr ^ PATTERN.
  assign imem_ack_i  = imem_req_o && (mem_cnt == wait_states);
  assign imem_data_i = imem_addr_o ^ PATTERN;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) mem_cnt <= 2'd0;
    else if (!imem_req_o || imem_ack_i) mem_cnt <= 2'd0;
    else mem_cnt <= mem_cnt + 2'd1;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] pc, input logic valid);
    ifid_t e;
    e.tag   = tag;
    e.pc    = valid ? pc : 32'h0;
    e.instr = valid ? (pc ^ PATTERN) : 32'h0;
    e.valid = valid;
    sb_q.push_back(e);
  endtask

  task automatic check_output();
    ifid_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    check_value({e.tag, "_pc"}, pc_o, e.pc);
    check_value({e.tag, "_pc4"}, pc_plus4_o, e.valid ? e.pc + 32'd4 : 32'h0);
    check_value({e.tag, "_instr"}, instr_o, e.instr);
    check_value({e.tag, "_valid"}, {31'h0, valid_o}, {31'h0, e.valid});
  endtask

  task automatic apply_stimulus(input logic pcw, input logic ifw, input logic fl,
                                input logic [31:0] tgt);
    pc_write_i      = pcw;
    if_id_write_i   = ifw;
    flush_i         = fl;
    branch_target_i = tgt;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i       = 1'b0;
    wait_states = 2'd0;
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    expect_ifid("reset", 32'h0, 1'b0);
    check_output();
    check_value("reset_req", {31'h0, imem_req_o}, 32'h0);

    rst_i = 1'b1;
    #1;
    check_value("release_req", {31'h0, imem_req_o}, 32'h1);
    check_value("release_addr", imem_addr_o, 32'h0);

    // Zero-wait streaming: one instruction per cycle.
    step(); expect_ifid("stream0", 32'h0, 1'b1); check_output();
    step(); expect_ifid("stream4", 32'h4, 1'b1); check_output();

    // Load-use stall while pc=8 is acked.
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step(); expect_ifid("stall_hold", 32'h4, 1'b1); check_output();
    check_value("stall_req", {31'h0, imem_req_o}, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step(); expect_ifid("stall_release", 32'h8, 1'b1); check_output();
    check_value("after_release_req", {31'h0, imem_req_o}, 32'h1);
    check_value("after_release_addr", imem_addr_o, 32'hC);

    // Flush on a FETCH ack.
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h40);
    step(); expect_ifid("flush_bubble", 32'h0, 1'b0); check_output();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step(); expect_ifid("flush_target", 32'h40, 1'b1); check_output();

    // Three wait states, flush in the second waiting cycle.
    wait_states = 2'd3;
    step(); expect_ifid("wait0", 32'h0, 1'b0); check_output();
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h80);
    step();
    check_value("discard_req", {31'h0, imem_req_o}, 32'h1);
    check_value("discard_addr", imem_addr_o, 32'h44);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check_value("discard_addr2", imem_addr_o, 32'h44);
    step(); expect_ifid("discard_drop", 32'h0, 1'b0); check_output();
    check_value("redirect_addr", imem_addr_o, 32'h80);
    wait_states = 2'd0;
    step(); expect_ifid("redirect_fetch", 32'h80, 1'b1); check_output();

    // Flush and stall together while holding a buffered word.
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    step(); expect_ifid("hold_enter", 32'h80, 1'b1); check_output();
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h100);
    step(); expect_ifid("hold_flush", 32'h0, 1'b0); check_output();
    check_value("hold_flush_addr", imem_addr_o, 32'h100);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step(); expect_ifid("hold_target", 32'h100, 1'b1); check_output();
    step(); expect_ifid("hold_next", 32'h104, 1'b1); check_output();

    // Reset while a request is outstanding.
    wait_states = 2'd3;
    step(); expect_ifid("pre_reset", 32'h0, 1'b0); check_output();
    step();
    rst_i = 1'b0;
    #1;
    expect_ifid("mid_reset", 32'h0, 1'b0); check_output();
    check_value("mid_reset_req", {31'h0, imem_req_o}, 32'h0);
    @(negedge clk_i);
    wait_states = 2'd0;
    rst_i = 1'b1;
    #1;
    check_value("rerelease_addr", imem_addr_o, 32'h0);
    check_value("rerelease_req", {31'h0, imem_req_o}, 32'h1);
    step(); expect_ifid("restart0", 32'h0, 1'b1); check_output();
    check_value("wrap_pc_a", w_pc, 32'hFFFF_FFFC);
    check_value("wrap_pc4_a", w_pc_plus4, 32'h0);
    step(); expect_ifid("restart4", 32'h4, 1'b1); check_output();
    check_value("wrap_pc_b", w_pc, 32'h0);
    check_value("wrap_pc4_b", w_pc_plus4, 32'h4);
    check_value("wrap_valid", {31'h0, w_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
